// File: rtl/mux_arb_reg_pkg.sv
// Shared constants and helpers for the registered N-way mux/arbiter.
package mux_arb_reg_pkg;

  // Arbitration mode, matching the 1-bit mode input encoding.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } occ_e;

  // Legal parameter ranges.
  localparam int unsigned W_MIN = 1;
  localparam int unsigned W_MAX = 64;
  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

  // Ceiling log2, used to size channel-index fields.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester searching upward from ptr+1.
module rr_arbiter
  import mux_arb_reg_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  // Scan N positions after ptr, wrapping at N; the first hit wins.
  always_comb begin
    int unsigned c;
    c         = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!gnt_valid && req[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel arbiter (fixed select or round-robin) feeding a one-entry
// registered output with valid/ready handshake on both sides.
module mux_arb_reg
  import mux_arb_reg_pkg::*;
#(
  parameter  int unsigned W  = 32,
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  occ_e          occ;
  logic [SW-1:0] ptr;
  logic          load_ok;
  logic          fix_valid;
  logic          rr_valid;
  logic [SW-1:0] rr_idx;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          xfer;

  rr_arbiter #(.N(N), .SW(SW)) u_rr (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign out_valid = (occ == ST_FULL);
  assign load_ok   = !out_valid || out_ready;

  // Fixed-select grant; an out-of-range sel grants nothing.
  always_comb begin
    fix_valid = 1'b0;
    if (32'(sel) < N) fix_valid = in_valid[sel];
  end

  // Pick the active arbitration result and the granted channel's data.
  always_comb begin
    gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
    gnt_idx   = (mode == MODE_RR) ? rr_idx   : sel;
    gnt_data  = in_data[32'(gnt_idx)*W +: W];
  end

  // One-hot ready to the granted channel only when the register can load.
  always_comb begin
    in_ready = '0;
    if (gnt_valid && load_ok && !rst) in_ready[gnt_idx] = 1'b1;
  end

  assign xfer = |(in_ready & in_valid);

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= ST_EMPTY;
      out_data <= '0;
      out_chan <= '0;
      ptr      <= SW'(N - 1);
    end else if (xfer) begin
      occ      <= ST_FULL;
      out_data <= gnt_data;
      out_chan <= gnt_idx;
      if (mode == MODE_RR) ptr <= gnt_idx;
    end else if (out_ready) begin
      occ <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed + random bench for mux_arb_reg (N=4, W=32) with a scoreboard queue.
module tb_mux_arb_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [W+SW-1:0] q[$];
  logic            m_valid;
  int              m_ptr;

  mux_arb_reg #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: predict grant, check DUT handshake/outputs, update model.
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [W+SW-1:0] e;
    int  g;
    bit  gv;
    bit  lok;
    @(negedge clk);
    gv = 0;
    g  = 0;
    if (!rst) begin
      if (mode == 1'b0) begin
        if (int'(sel) < N && in_valid[sel]) begin gv = 1; g = int'(sel); end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c = (m_ptr + k) % N;
          if (!gv && in_valid[c]) begin gv = 1; g = c; end
        end
      end
    end
    lok     = !m_valid || out_ready;
    exp_rdy = '0;
    if (gv && lok) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'(q.size()), 64'd1);
      end else begin
        e = q[0];
        chk("out_data", 64'(out_data), 64'(e[W-1:0]));
        chk("out_chan", 64'(out_chan), 64'(e[W+SW-1:W]));
        if (out_ready) void'(q.pop_front());
      end
    end
    if (rst) begin
      q.delete();
      m_valid = 0;
      m_ptr   = N - 1;
    end else begin
      if (exp_rdy != 0) begin
        q.push_back({SW'(g), in_data[g*W +: W]});
        if (mode) m_ptr = g;
      end
      m_valid = (exp_rdy != 0) || (m_valid && !out_ready);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_data = '0; in_valid = '0; mode = 0; sel = '0; out_ready = 0;
    m_valid = 0; m_ptr = N - 1;
    @(posedge clk); #1;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_chan", 64'(out_chan), 64'd0);

    // Fixed select stepping through channels 0..3.
    rst = 0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(i);
    in_valid = 4'b1111; out_ready = 1; mode = 0;
    for (int i = 0; i < N; i++) begin sel = SW'(i); step(); end
    in_valid = '0; step(); step();

    // Round-robin from reset pointer: 0,1,2,3,0.
    mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    chk("rr_last_chan", 64'(out_chan), 64'd0);
    // Alternating 1,3 requesters.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_1010_ready", 64'(in_ready & 4'b0101), 64'd0);
    end
    in_valid = '0; step(); step();

    // Backpressure holding ch2 data.
    mode = 0; sel = 2; in_valid = 4'b1111; step();
    out_ready = 0; sel = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", 64'(out_data), 64'h2);
      chk("bp_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1; step(); step();
    chk("bp_next_data", 64'(out_data), 64'h3);
    in_valid = '0; step(); step();

    // Fixed sel=3 with channel 3 idle: nothing granted.
    sel = 3; in_valid = 4'b0111;
    for (int i = 0; i < 3; i++) step();
    chk("sel3_idle_valid", 64'(out_valid), 64'd0);

    // Reset while streaming, then round-robin restarts at channel 0.
    mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    rst = 1; step();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    rst = 0;
    #1;
    chk("restart_ready", 64'(in_ready), 64'b0001);
    step(); step();

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel = SW'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
MUX_ARB_REG -- requirements
Module: mux_arb_reg

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning data width per channel (1..64).
REQ-002 The block SHALL have parameter N, default 4, meaning channel count (2..16).
REQ-003 The block SHALL have derived constant SW = clog2(N), the select/channel-index width.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_data  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready; at most one bit high per cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SW  channel index used in fixed-select mode.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_chan  output  SW  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  output register holds unconsumed data.
REQ-014 out_ready  input  1  downstream accepts out_data.

Function
REQ-015 The block SHALL hold a one-entry output register; state EMPTY when out_valid=0, FULL when out_valid=1.
REQ-016 load_ok SHALL be (!out_valid || out_ready), combinational.
REQ-017 Fixed mode: grant SHALL be channel sel when sel<N and in_valid[sel]=1; otherwise no grant.
REQ-018 sel>=N in fixed mode SHALL produce no grant and leave all in_ready low.
REQ-019 Round-robin mode: grant SHALL be the first channel with in_valid=1, searching from ptr+1 upward mod N.
REQ-020 ptr SHALL update to the granted index only on a transfer; it SHALL hold otherwise, including in fixed mode.
REQ-021 in_ready[g] SHALL be high iff channel g is granted and load_ok=1; all other bits SHALL be low.
REQ-022 On a transfer (in_valid[g] && in_ready[g]), out_data SHALL load in_data channel g, out_chan SHALL load g, and out_valid SHALL be 1 on the next edge.
REQ-023 Latency SHALL be exactly 1 cycle from input transfer to out_valid.
REQ-024 With out_valid && out_ready and no new transfer, out_valid SHALL clear on the next edge; out_data and out_chan SHALL hold.
REQ-025 With a simultaneous drain and load, the register SHALL stay FULL with the new data, giving full throughput of one word per cycle.
REQ-026 While FULL and out_ready=0, out_data, out_chan and out_valid SHALL hold stable, and all in_ready bits SHALL be low.
REQ-027 A mode or sel change SHALL affect only the arbitration of the same cycle and SHALL not corrupt or drop the word already in the register.
REQ-028 Round-robin wrap-around: from ptr=N-1 the search SHALL start at channel 0.

Reset
REQ-029 When rst=1 at a clock edge, out_valid SHALL be 0, out_data 0, out_chan 0, and ptr N-1, so channel 0 has first round-robin priority.
REQ-030 During rst=1, in_ready SHALL be all zeros, and no transfer SHALL occur.
REQ-031 Reset asserted mid-operation SHALL discard the held word with no partial update.

Structure
REQ-032 A shared package SHALL hold the clog2 function, the constants MODE_FIXED=0 and MODE_RR=1, and parameter range limits.
REQ-033 Round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs: req[N], ptr[SW]; outputs: gnt_valid, gnt_idx[SW]), purely combinational.
REQ-034 ptr and the output register SHALL reside in mux_arb_reg, with no other sub-modules.

Verification (N=4, W=32)
REQ-035 Fixed mode, in_data ch0..3 = 0,1,2,3, in_valid=4'b1111, out_ready=1, sel stepped 0,1,2,3 per cycle -> out_data 0,1,2,3 each one cycle later, and out_chan equals sel delayed one cycle.
REQ-036 Round-robin after reset, in_valid=4'b1111, out_ready=1 -> out_chan sequence 0,1,2,3,0 with out_valid continuously 1 from cycle 1.
REQ-037 Round-robin, in_valid=4'b1010, out_ready=1 -> out_chan alternates 1,3,1,3, and channels 0 and 2 never see in_ready.
REQ-038 Backpressure: FULL with out_data=32'h2, then out_ready=0 for 3 cycles -> out_data holds 32'h2 and in_ready=0; when out_ready returns to 1, the next word appears in the following cycle and nothing is lost or duplicated.
REQ-039 Fixed mode with sel=3 and in_valid=4'b0111 -> no grant and out_valid stays 0.
REQ-040 rst=1 asserted while FULL and streaming -> next cycle out_valid=0 and out_data=0; after release, the round-robin grant restarts at channel 0.
